// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter in front of one shared memory-mapped peripheral.
// Each transfer is abortable by a BUSY-cycle timeout that returns a fixed read word.
module iomem_arbiter #(
  parameter int unsigned TIMEOUT       = 255,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_valid,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic        err_timeout,
  output logic        grant
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        s_valid_q, s_valid_d;
  logic [3:0]  s_wstrb_q, s_wstrb_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        m0_ready_q, m0_ready_d;
  logic        m1_ready_q, m1_ready_d;
  logic        err_q, err_d;
  logic        sel;
  logic        done;
  logic [31:0] rdata_cap;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    s_valid_d  = s_valid_q;
    s_wstrb_d  = s_wstrb_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    cnt_d      = cnt_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    err_d      = 1'b0;
    // A tie goes to the master that was not served last.
    sel        = (m0_valid && m1_valid) ? ~grant_q : m1_valid;
    done       = 1'b0;
    rdata_cap  = s_rdata;

    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          grant_d   = sel;
          s_wstrb_d = sel ? m1_wstrb : m0_wstrb;
          s_addr_d  = sel ? m1_addr  : m0_addr;
          s_wdata_d = sel ? m1_wdata : m0_wdata;
          cnt_d     = 16'd0;
          s_valid_d = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (s_ready) begin
          done = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          done      = 1'b1;
          rdata_cap = TIMEOUT_RDATA;
          err_d     = 1'b1;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
        if (done) begin
          s_valid_d = 1'b0;
          state_d   = RESP;
          if (grant_q) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = rdata_cap;
          end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = rdata_cap;
          end
        end
      end
      RESP: state_d = IDLE;
      default: begin
        state_d   = IDLE;
        s_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b1;
      s_valid_q  <= 1'b0;
      s_wstrb_q  <= 4'd0;
      s_addr_q   <= 32'd0;
      s_wdata_q  <= 32'd0;
      cnt_q      <= 16'd0;
      m0_rdata_q <= 32'd0;
      m1_rdata_q <= 32'd0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      s_valid_q  <= s_valid_d;
      s_wstrb_q  <= s_wstrb_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      cnt_q      <= cnt_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      err_q      <= err_d;
    end
  end

  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign m0_ready    = m0_ready_q;
  assign m1_ready    = m1_ready_q;
  assign s_valid     = s_valid_q;
  assign s_wstrb     = s_wstrb_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign err_timeout = err_q;
  assign grant       = grant_q;

endmodule

// File: doc/iomem_arbiter.md
IOMEM_ARBITER -- requirements
Module: iomem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of BUSY cycles allowed before a transfer is aborted (valid range 1..65535).
REQ-002 The block SHALL have parameter TIMEOUT_RDATA, default 32'hFFFF_FFFF, meaning the read data returned on an aborted transfer.
REQ-003 clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 m0_valid / m1_valid  input  1  request from master 0 (CPU) / master 1 (sequencer).
REQ-006 m0_wstrb / m1_wstrb  input  4  byte write strobes; 0 means read.
REQ-007 m0_addr / m1_addr  input  32  request address.
REQ-008 m0_wdata / m1_wdata  input  32  write data.
REQ-009 m0_rdata / m1_rdata  output  32  response data.
REQ-010 m0_ready / m1_ready  output  1  one-cycle completion pulse.
REQ-011 s_valid  output  1  request to the shared peripheral.
REQ-012 s_wstrb, s_addr, s_wdata  output  4/32/32  latched request fields.
REQ-013 s_rdata  input  32  peripheral read data.
REQ-014 s_ready  input  1  peripheral completion.
REQ-015 err_timeout  output  1  one-cycle pulse when a transfer is aborted.
REQ-016 grant  output  1  index of the master currently or last served.

Function
REQ-017 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-018 IDLE: if exactly one mX_valid is high, that master SHALL be granted.
REQ-019 IDLE: if both are high, the master not equal to `grant` SHALL be granted (round-robin); after reset the first tie SHALL go to m0.
REQ-020 On grant, the master's wstrb, addr and wdata SHALL be latched, grant updated, the timeout counter cleared, and the FSM SHALL enter BUSY.
REQ-021 BUSY: s_valid SHALL be 1 and s_wstrb/s_addr/s_wdata SHALL be held stable from the latched values.
REQ-022 BUSY, s_ready=1: s_rdata SHALL be captured and the FSM SHALL go to RESP; s_valid SHALL be 0 the following cycle.
REQ-023 BUSY, s_ready=0: the counter SHALL increment by 1 and saturate (16-bit).
REQ-024 When the counter reaches TIMEOUT-1 with s_ready still 0, the block SHALL capture TIMEOUT_RDATA, pulse err_timeout for the same cycle RESP is entered, and go to RESP.
REQ-025 If s_ready=1 on the timeout cycle, s_ready SHALL win and no error is flagged.
REQ-026 RESP: the granted mX_ready SHALL be 1 for exactly one cycle with mX_rdata holding the captured data; the other master's ready SHALL stay 0; then the FSM SHALL return to IDLE.
REQ-027 mX_rdata SHALL hold its last value until the next RESP for that master.
REQ-028 Masters deassert valid in the cycle after ready; a request still valid in IDLE is treated as new.
REQ-029 Latency SHALL be: request in IDLE at cycle 0, s_valid at cycles 1..n, mX_ready at cycle n+1, where n = cycle s_ready is sampled.
REQ-030 Requester inputs SHALL be ignored outside IDLE.
REQ-031 Requester inputs SHALL NOT propagate combinationally to outputs.

Reset
REQ-032 On reset: state IDLE, s_valid=0, s_wstrb=0, s_addr=0, s_wdata=0, m0_ready=m1_ready=0, m0_rdata=m1_rdata=0, err_timeout=0, grant=1 (so m0 wins the first tie), counter=0.
REQ-033 Reset asserted mid-BUSY or mid-RESP SHALL drop s_valid and all ready outputs on the next edge, with no response delivered.

Verification
REQ-034 m0 write addr 0x0200_0000, wdata 0x0000_0003, wstrb 0xF; slave ready one cycle after s_valid -> s_valid cycles 1-2, m0_ready at cycle 3, m1_ready stays 0.
REQ-035 m0 and m1 both valid from reset, slave returns 0x11 then 0x22 -> m0 served first with rdata 0x11, then m1 with rdata 0x22, grant=0 then 1.
REQ-036 Both masters held continuously for 4 transfers -> grants alternate 0,1,0,1.
REQ-037 TIMEOUT=4, slave never ready -> s_valid high 4 cycles, err_timeout and m1_ready pulse together, m1_rdata=0xFFFF_FFFF.
REQ-038 s_ready asserted on the timeout cycle -> normal response, err_timeout=0.
REQ-039 Reset asserted during BUSY -> next cycle s_valid=0, no mX_ready, and a new m1 request is then served normally.
